// File: rtl/bit_counter_pkg.sv
// Shared types and defaults for the retriggerable bit counter.
// Holds the FSM state type, default sizing and the sizing check.
package bit_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LOAD_VAL_DEF = 8;
    localparam int CNT_W_DEF    = 4;

    // Counter must hold LOAD_VAL and the count must be at least one clock.
    function automatic bit cfg_ok(input int lv, input int w);
        longint span;
        span = longint'(1) << w;
        return (lv >= 1) && (span > longint'(lv));
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Retriggerable one-shot: newcount starts LOAD_VAL clocks, outcount pulses at expiry.
// Optional status outputs (busy, remaining) under BIT_COUNTER_STATUS_EN.
module bit_counter
    import bit_counter_pkg::*;
#(
    parameter int LOAD_VAL = LOAD_VAL_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             newcount,
`ifdef BIT_COUNTER_STATUS_EN
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
`endif
    output logic             outcount
);

    if (!cfg_ok(LOAD_VAL, CNT_W)) begin : g_cfg_err
        $error("bit_counter: need LOAD_VAL >= 1 and 2**CNT_W > LOAD_VAL");
    end

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOAD_VAL);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             out_n;

    // State, down-counter and pulse register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            outcount <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            outcount <= out_n;
        end
    end

    // Next state: a strobe always reloads, so it beats the terminal edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = 1'b0;
        if (newcount) begin
            state_n = RUN;
            cnt_n   = LOAD;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_n = '0;
                end
                RUN: begin
                    if (cnt == ONE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        out_n   = 1'b1;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef BIT_COUNTER_STATUS_EN
    assign busy      = (state == RUN);
    assign remaining = cnt;
`endif

endmodule

// File: tb/tb_bit_counter.sv
// Scoreboard bench for bit_counter: LOAD_VAL=8 and LOAD_VAL=1 instances.
// Expected pulse cycles are queued at each sampled strobe and popped when due.
`timescale 1ns/1ps
module tb_bit_counter;

    localparam int LV0 = 8;
    localparam int LV1 = 1;

    logic       clk;
    logic       rst;
    logic       newcount;
    logic       out0;
    logic       out1;
`ifdef BIT_COUNTER_STATUS_EN
    logic       busy0;
    logic       busy1;
    logic [3:0] rem0;
    logic [3:0] rem1;
`endif

    int unsigned vectors;
    int unsigned errors;
    int unsigned cyc;
    int unsigned q0[$];
    int unsigned q1[$];

    bit_counter #(.LOAD_VAL(LV0), .CNT_W(4)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .newcount (newcount),
`ifdef BIT_COUNTER_STATUS_EN
        .busy     (busy0),
        .remaining(rem0),
`endif
        .outcount (out0)
    );

    bit_counter #(.LOAD_VAL(LV1), .CNT_W(4)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .newcount (newcount),
`ifdef BIT_COUNTER_STATUS_EN
        .busy     (busy1),
        .remaining(rem1),
`endif
        .outcount (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: absolute due-cycle per instance, compared 1 ns after each edge.
    always @(posedge clk) begin
        bit r;
        bit n;
        bit due0;
        bit due1;
        bit bz0;
        bit bz1;
        r = rst;
        n = newcount;
        if (!r) begin
            q0.delete();
            q1.delete();
        end else if (n) begin
            q0.delete();
            q0.push_back(cyc + LV0);
            q1.delete();
            q1.push_back(cyc + LV1);
        end
        #1;
        due0 = (q0.size() != 0) && (q0[0] == cyc);
        due1 = (q1.size() != 0) && (q1[0] == cyc);
        chk("out_lv8", 32'(out0), 32'(due0));
        chk("out_lv1", 32'(out1), 32'(due1));
`ifdef BIT_COUNTER_STATUS_EN
        bz0 = (q0.size() != 0) && (q0[0] > cyc);
        bz1 = (q1.size() != 0) && (q1[0] > cyc);
        chk("busy_lv8", 32'(busy0), 32'(bz0));
        chk("busy_lv1", 32'(busy1), 32'(bz1));
        chk("rem_lv8", 32'(rem0), bz0 ? q0[0] - cyc : 32'd0);
        chk("rem_lv1", 32'(rem1), bz1 ? q1[0] - cyc : 32'd0);
`else
        bz0 = 1'b0;
        bz1 = 1'b0;
`endif
        if (due0) void'(q0.pop_front());
        if (due1) void'(q1.pop_front());
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        newcount = 1'b1;
        @(negedge clk);
        newcount = 1'b0;
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        cyc      = 0;
        rst      = 1'b0;
        newcount = 1'b1;
        // reset with strobe held: nothing may start
        idle(2);
        rst      = 1'b1;
        newcount = 1'b0;
        idle(12);
        // single shot
        pulse();
        idle(12);
        // retrigger after 3 cycles
        pulse();
        idle(2);
        pulse();
        idle(12);
        // strobe on the terminal edge
        pulse();
        idle(LV0 - 1);
        pulse();
        idle(12);
        // strobe in the cycle outcount is high
        pulse();
        idle(LV0);
        pulse();
        idle(12);
        // strobe held for 4 cycles
        newcount = 1'b1;
        idle(4);
        newcount = 1'b0;
        idle(12);
        // reset mid-count, then a normal shot
        pulse();
        idle(3);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(12);
        pulse();
        idle(12);
        // random strobes with occasional resets
        for (int i = 0; i < 300; i++) begin
            newcount = ($urandom_range(0, 6) == 0);
            rst      = ($urandom_range(0, 40) != 0);
            @(negedge clk);
        end
        newcount = 1'b0;
        rst      = 1'b1;
        idle(12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
